pedestrian_signal: RTL

PEDESTRIAN_SIGNAL -- requirements
Module: pedestrian_signal

---
 rtl/pedestrian_signal.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pedestrian_signal.sv
`default_nettype none
// ============================================================================
// Module   : pedestrian_signal
// Purpose  : Pedestrian crossing lamps slaved to a car semaphore. Build macro
//            PED_BLINK_EN adds a flashing-green BLINK phase.
// Revision : 1.0
// ============================================================================
module pedestrian_signal #(
  parameter int CLK_FREQ     = 12000000,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int CLEAR_SEC    = 1,
  parameter int WALK_SEC     = 3,
  parameter int BLINK_SEC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buton,
  input  logic       rosu,
  input  logic       galben,
  input  logic       verde,
  output logic       buton_req_n,
  output logic       ped_rosu,
  output logic       ped_verde,
  output logic       wait_led,
  output logic [3:0] count_display,
  output logic       fault
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = 16;
`ifdef PED_BLINK_EN
  localparam int WALK_TICKS = WALK_SEC;
  localparam int WALK_TAIL  = BLINK_SEC;
`else
  localparam int WALK_TICKS = WALK_SEC + BLINK_SEC;
  localparam int WALK_TAIL  = 0;
`endif

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_WALK  = 3'd2,
    ST_BLINK = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            btn_meta_q, btn_s_q;
  logic [2:0]      lamp_meta_q, lamp_s_q;
  logic [PW-1:0]   phase_q, phase_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            req_q, req_d;
  logic            bad_q, bad_d;
  logic            vok_q, vok_d;
  logic            blink_d;
  logic            ped_rosu_d, ped_verde_d, fault_d;
  logic [3:0]      count_d;

  logic tick, press, lamps_valid, red_only, green_only, fault_now;
  int   rem;

  // Lamp bits ordered {rosu, galben, verde}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q  <= 1'b1;
      btn_s_q     <= 1'b1;
      lamp_meta_q <= 3'b000;
      lamp_s_q    <= 3'b000;
    end else begin
      btn_meta_q  <= buton;
      btn_s_q     <= btn_meta_q;
      lamp_meta_q <= {rosu, galben, verde};
      lamp_s_q    <= lamp_meta_q;
    end
  end

  assign tick        = (phase_q == PW'(CLK_FREQ - 1));
  assign red_only    = (lamp_s_q == 3'b100);
  assign green_only  = (lamp_s_q == 3'b001);
  assign lamps_valid = red_only || green_only || (lamp_s_q == 3'b010);
  assign press       = !btn_s_q && (deb_q == DW'(DEBOUNCE_CYC - 1));
  assign fault_now   = tick && !lamps_valid && bad_q;

  always_comb begin
    phase_d = tick ? '0 : phase_q + PW'(1);
    deb_d   = deb_q;
    if (btn_s_q)
      deb_d = '0;
    else if (deb_q != DW'(DEBOUNCE_CYC))
      deb_d = deb_q + DW'(1);
    bad_d = !lamps_valid && (tick || bad_q);
    vok_d = green_only && (tick || vok_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (red_only && req_q) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (!lamp_s_q[2]) state_d = ST_STOP;
        else if (tick && tcnt_q == TW'(CLEAR_SEC - 1)) state_d = ST_WALK;
      end
      ST_WALK: begin
        if (!lamp_s_q[2]) state_d = ST_STOP;
`ifdef PED_BLINK_EN
        else if (tick && tcnt_q == TW'(WALK_TICKS - 1)) state_d = ST_BLINK;
`else
        else if (tick && tcnt_q == TW'(WALK_TICKS - 1)) state_d = ST_STOP;
`endif
      end
`ifdef PED_BLINK_EN
      ST_BLINK: begin
        if (!lamp_s_q[2]) state_d = ST_STOP;
        else if (tick && tcnt_q == TW'(BLINK_SEC - 1)) state_d = ST_STOP;
      end
`endif
      ST_FAULT: if (tick && green_only && vok_q) state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
    if (fault_now) state_d = ST_FAULT;

    tcnt_d = tcnt_q;
    if (state_d != state_q)
      tcnt_d = '0;
    else if (tick && tcnt_q != '1)
      tcnt_d = tcnt_q + TW'(1);

    // Request is consumed on entry to WALK and discarded on entry to FAULT
    req_d = req_q;
    if (press && state_q == ST_STOP) req_d = 1'b1;
    if (state_d != state_q && (state_d == ST_WALK || state_d == ST_FAULT)) req_d = 1'b0;

    rem = 0;
    if (state_d == ST_WALK)  rem = WALK_TICKS + WALK_TAIL - int'(tcnt_d);
    if (state_d == ST_BLINK) rem = BLINK_SEC - int'(tcnt_d);
    count_d = (rem > 15) ? 4'd15 : 4'(rem);

    ped_rosu_d  = (state_d == ST_STOP) || (state_d == ST_CLEAR) || (state_d == ST_FAULT);
    ped_verde_d = (state_d == ST_WALK) || ((state_d == ST_BLINK) && blink_d);
    fault_d     = (state_d == ST_FAULT);
  end

`ifdef PED_BLINK_EN
  localparam int BLINK_HALF = (CLK_FREQ / 4 > 0) ? CLK_FREQ / 4 : 1;
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q;

  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (state_d == ST_BLINK && state_q != ST_BLINK) begin
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (state_q == ST_BLINK) begin
      if (bcnt_q == BW'(BLINK_HALF - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end
`else
  assign blink_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_STOP;
      phase_q       <= '0;
      deb_q         <= '0;
      tcnt_q        <= '0;
      req_q         <= 1'b0;
      bad_q         <= 1'b0;
      vok_q         <= 1'b0;
      buton_req_n   <= 1'b1;
      wait_led      <= 1'b0;
      ped_rosu      <= 1'b1;
      ped_verde     <= 1'b0;
      count_display <= 4'd0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      deb_q         <= deb_d;
      tcnt_q        <= tcnt_d;
      req_q         <= req_d;
      bad_q         <= bad_d;
      vok_q         <= vok_d;
      buton_req_n   <= ~req_d;
      wait_led      <= req_d;
      ped_rosu      <= ped_rosu_d;
      ped_verde     <= ped_verde_d;
      count_display <= count_d;
      fault         <= fault_d;
    end
  end

endmodule
`default_nettype wire
